// File: rtl/serial_sub_pkg.sv
// ---------------------------------------------------------------------------
// serial_sub_pkg
//
// Shared definitions for the bit-serial subtractor:
//   - state_t        : FSM state encoding (IDLE / SHIFT / DONE)
//   - DEFAULT_WIDTH  : default operand/result width
//   - sat_pos_limit  : most-positive two's-complement value for a width
//   - sat_neg_limit  : most-negative two's-complement value for a width
//
// The saturation helpers return MAX_WIDTH-bit values; callers truncate to
// their own width, so any width up to MAX_WIDTH is supported.
// ---------------------------------------------------------------------------
package serial_sub_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam int DEFAULT_WIDTH = 8;
   localparam int MAX_WIDTH     = 64;

   // 0111...1 : largest signed value representable in 'width' bits
   function automatic logic [MAX_WIDTH-1:0] sat_pos_limit(input int width);
      return (MAX_WIDTH'(1) << (width - 1)) - MAX_WIDTH'(1);
   endfunction

   // 1000...0 : smallest signed value representable in 'width' bits
   function automatic logic [MAX_WIDTH-1:0] sat_neg_limit(input int width);
      return MAX_WIDTH'(1) << (width - 1);
   endfunction

endpackage

// File: rtl/serial_sub_bitcell.sv
// ---------------------------------------------------------------------------
// serial_sub_bitcell
//
// Combinational one-bit full subtractor, built as a full adder on a and ~b.
// A subtract chain starts with carry_in = 1, so that a + ~b + 1 = a - b.
//
// Ports:
//   a_i       in   minuend bit
//   b_i       in   subtrahend bit
//   carry_in  in   incoming carry (1 = no borrow pending)
//   d         out  difference bit
//   carry_out out  outgoing carry (0 = borrow out of this bit)
// ---------------------------------------------------------------------------
module serial_sub_bitcell
   import serial_sub_pkg::*;
(
   input  logic a_i,
   input  logic b_i,
   input  logic carry_in,
   output logic d,
   output logic carry_out
);

   logic b_inv;

   assign b_inv     = ~b_i;
   assign d         = a_i ^ b_inv ^ carry_in;
   assign carry_out = (a_i & b_inv) | (a_i & carry_in) | (b_inv & carry_in);

endmodule

// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial two's-complement subtractor: c = a - b, one bit per clock,
// LSB first. Operands are captured on start (in IDLE or DONE); WIDTH clocks
// later the result and flags are committed and done pulses for one cycle.
// Outputs hold their last committed values between operations.
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   synchronous active-low reset
//   start     in   operation request (ignored while busy)
//   a, b      in   minuend / subtrahend, captured on accepted start
//   busy      out  high while bits are being processed
//   done      out  one-cycle pulse when c and flags are updated
//   c         out  difference
//   negative  out  c[WIDTH-1]
//   zero      out  c == 0 (0 after reset: no result yet)
//   overflow  out  signed overflow of a - b
//   borrow    out  unsigned borrow (a < b)
//
// Build option:
//   SERIAL_SUB_SAT_EN  when defined, a signed overflow commits the
//                      saturated limit instead of the wrapped result.
// ---------------------------------------------------------------------------
module serial_subtractor
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] c,
   output logic             negative,
   output logic             zero,
   output logic             overflow,
   output logic             borrow
);

   localparam int              CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

`ifdef SERIAL_SUB_SAT_EN
   localparam logic [WIDTH-1:0] SAT_POS = WIDTH'(sat_pos_limit(WIDTH));
   localparam logic [WIDTH-1:0] SAT_NEG = WIDTH'(sat_neg_limit(WIDTH));
`endif

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   a_sh_q, a_sh_d;
   logic [WIDTH-1:0]   b_sh_q, b_sh_d;
   logic               a_msb_q, a_msb_d;
   logic               b_msb_q, b_msb_d;
   logic               carry_q, carry_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-2:0]   res_q, res_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [WIDTH-1:0]   c_q, c_d;
   logic               negative_q, negative_d;
   logic               zero_q, zero_d;
   logic               overflow_q, overflow_d;
   logic               borrow_q, borrow_d;

   logic               bit_d;
   logic               bit_carry;
   logic [WIDTH-1:0]   res_full;
   logic               ovf_next;
   logic [WIDTH-1:0]   commit_c;

   serial_sub_bitcell u_bitcell (
      .a_i       (a_sh_q[0]),
      .b_i       (b_sh_q[0]),
      .carry_in  (carry_q),
      .d         (bit_d),
      .carry_out (bit_carry)
   );

   // Next-state logic. res_q only needs WIDTH-1 bits: the last difference
   // bit is combined with it directly at commit time.
   always_comb begin
      state_d    = state_q;
      a_sh_d     = a_sh_q;
      b_sh_d     = b_sh_q;
      a_msb_d    = a_msb_q;
      b_msb_d    = b_msb_q;
      carry_d    = carry_q;
      cnt_d      = cnt_q;
      res_d      = res_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      c_d        = c_q;
      negative_d = negative_q;
      zero_d     = zero_q;
      overflow_d = overflow_q;
      borrow_d   = borrow_q;

      res_full = {bit_d, res_q};
      ovf_next = (a_msb_q ^ b_msb_q) & (bit_d ^ a_msb_q);
      commit_c = res_full;
`ifdef SERIAL_SUB_SAT_EN
      if (ovf_next) begin
         commit_c = a_msb_q ? SAT_NEG : SAT_POS;
      end
`endif

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               a_sh_d  = a;
               b_sh_d  = b;
               a_msb_d = a[WIDTH-1];
               b_msb_d = b[WIDTH-1];
               carry_d = 1'b1;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = SHIFT;
            end else begin
               busy_d  = 1'b0;
               state_d = IDLE;
            end
         end

         SHIFT: begin
            a_sh_d  = a_sh_q >> 1;
            b_sh_d  = b_sh_q >> 1;
            carry_d = bit_carry;
            res_d   = (WIDTH-1)'(res_full >> 1);
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_BIT) begin
               state_d    = DONE;
               busy_d     = 1'b0;
               done_d     = 1'b1;
               c_d        = commit_c;
               negative_d = commit_c[WIDTH-1];
               zero_d     = (commit_c == '0);
               overflow_d = ovf_next;
               borrow_d   = ~bit_carry;
            end
         end

         default: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers; reset discards any operation in flight.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         a_sh_q     <= '0;
         b_sh_q     <= '0;
         a_msb_q    <= 1'b0;
         b_msb_q    <= 1'b0;
         carry_q    <= 1'b0;
         cnt_q      <= '0;
         res_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         c_q        <= '0;
         negative_q <= 1'b0;
         zero_q     <= 1'b0;
         overflow_q <= 1'b0;
         borrow_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         a_sh_q     <= a_sh_d;
         b_sh_q     <= b_sh_d;
         a_msb_q    <= a_msb_d;
         b_msb_q    <= b_msb_d;
         carry_q    <= carry_d;
         cnt_q      <= cnt_d;
         res_q      <= res_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         c_q        <= c_d;
         negative_q <= negative_d;
         zero_q     <= zero_d;
         overflow_q <= overflow_d;
         borrow_q   <= borrow_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign c        = c_q;
   assign negative = negative_q;
   assign zero     = zero_q;
   assign overflow = overflow_q;
   assign borrow   = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// ---------------------------------------------------------------------------
// tb_serial_subtractor
//
// Self-checking bench for serial_subtractor (WIDTH = 8). Directed vectors
// come from a table, random operands are checked against an arithmetic
// model of a - b, and hand-written sequences cover start-while-busy,
// back-to-back starts and reset in the middle of an operation.
// Honours SERIAL_SUB_SAT_EN for the expected saturated results.
// ---------------------------------------------------------------------------
module tb_serial_subtractor;

   localparam int WIDTH = 8;
   localparam int FULL  = 1 << WIDTH;
   localparam int HALF  = 1 << (WIDTH - 1);

`ifdef SERIAL_SUB_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   typedef struct {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [WIDTH-1:0] c;
      logic             neg;
      logic             zero;
      logic             ovf;
      logic             borrow;
   } vec_t;

   logic             clk;
   logic             rst_n;
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] c;
   logic             negative;
   logic             zero;
   logic             overflow;
   logic             borrow;

   int checks;
   int errors;

   serial_subtractor #(.WIDTH(WIDTH)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .a        (a),
      .b        (b),
      .busy     (busy),
      .done     (done),
      .c        (c),
      .negative (negative),
      .zero     (zero),
      .overflow (overflow),
      .borrow   (borrow)
   );

   // Free-running clock, 10 time units per period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: a - b from integer arithmetic on the unsigned and signed
   // interpretations of the operands.
   function automatic vec_t model(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
      vec_t r;
      int   ua, ub, sa, sb, sd, cu;
      ua = int'(av);
      ub = int'(bv);
      sa = (ua >= HALF) ? ua - FULL : ua;
      sb = (ub >= HALF) ? ub - FULL : ub;
      sd = sa - sb;
      cu = (ua - ub + FULL) % FULL;
      r.a      = av;
      r.b      = bv;
      r.ovf    = (sd >= HALF) || (sd < -HALF);
      r.borrow = (ua < ub);
      if (SAT && r.ovf) begin
         cu = (sa < 0) ? HALF : HALF - 1;
      end
      r.c    = WIDTH'(cu);
      r.neg  = (cu >= HALF);
      r.zero = (cu == 0);
      return r;
   endfunction

   task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic checkOutput(input string tag, input vec_t e);
      checkVal({tag, ".c"},        32'(c),        32'(e.c));
      checkVal({tag, ".negative"}, 32'(negative), 32'(e.neg));
      checkVal({tag, ".zero"},     32'(zero),     32'(e.zero));
      checkVal({tag, ".overflow"}, 32'(overflow), 32'(e.ovf));
      checkVal({tag, ".borrow"},   32'(borrow),   32'(e.borrow));
   endtask

   task automatic checkReset(input string tag);
      checkVal({tag, ".busy"},     32'(busy),     32'd0);
      checkVal({tag, ".done"},     32'(done),     32'd0);
      checkVal({tag, ".c"},        32'(c),        32'd0);
      checkVal({tag, ".negative"}, 32'(negative), 32'd0);
      checkVal({tag, ".zero"},     32'(zero),     32'd0);
      checkVal({tag, ".overflow"}, 32'(overflow), 32'd0);
      checkVal({tag, ".borrow"},   32'(borrow),   32'd0);
   endtask

   // Presents operands with a one-cycle start pulse; returns one negedge
   // after the capturing edge, with the operand inputs scrambled so a late
   // capture would be visible.
   task automatic applyStimulus(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
      @(negedge clk);
      a     = av;
      b     = bv;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      a     = ~av;
      b     = ~bv;
   endtask

   // Waits (bounded) for done. first_k is the index of the current negedge
   // counted from the start edge; edges returns the index of the edge that
   // committed the result, or -1 if done never arrived.
   task automatic waitDone(input int first_k, output int edges, output int busy_cycles);
      edges       = -1;
      busy_cycles = 0;
      for (int k = first_k; k <= first_k + 3 * WIDTH; k++) begin
         if (done === 1'b1) begin
            edges = k - 1;
            break;
         end
         if (busy === 1'b1) busy_cycles++;
         @(negedge clk);
      end
   endtask

   // Full operation: start, wait, check latency, busy length, outputs and
   // the single-cycle done pulse.
   task automatic runOp(input string tag, input vec_t e);
      int edges, bc;
      applyStimulus(e.a, e.b);
      waitDone(1, edges, bc);
      checkVal({tag, ".latency"}, 32'(edges), 32'(WIDTH));
      checkVal({tag, ".busy_cycles"}, 32'(bc), 32'(WIDTH));
      checkOutput(tag, e);
      @(negedge clk);
      checkVal({tag, ".done_pulse_end"}, 32'(done), 32'd0);
      checkVal({tag, ".c_held"}, 32'(c), 32'(e.c));
   endtask

   // Directed table, random operands, then the multi-cycle corner sequences.
   initial begin
      vec_t tbl[$];
      vec_t e;
      int   edges, bc, done_seen;

      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      start  = 1'b1;
      a      = 8'hFF;
      b      = 8'h01;

      // Reset held with start high: reset must win.
      repeat (3) @(negedge clk);
      checkReset("reset_with_start");
      rst_n = 1'b1;
      start = 1'b0;
      @(negedge clk);
      checkReset("after_reset_idle");

      tbl.push_back('{8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0});
      tbl.push_back('{8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, 1'b0, 1'b1});
      tbl.push_back('{8'h42, 8'h42, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0});
      tbl.push_back('{8'h80, 8'h01, SAT ? 8'h80 : 8'h7F, SAT, 1'b0, 1'b1, 1'b0});
      tbl.push_back('{8'h7F, 8'hFF, SAT ? 8'h7F : 8'h80, !SAT, 1'b0, 1'b1, 1'b1});
      tbl.push_back('{8'h00, 8'h80, SAT ? 8'h7F : 8'h80, !SAT, 1'b0, 1'b1, 1'b1});
      tbl.push_back('{8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0});
      tbl.push_back('{8'hFF, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0});
      tbl.push_back('{8'h80, 8'h7F, SAT ? 8'h80 : 8'h01, SAT, 1'b0, 1'b1, 1'b0});

      foreach (tbl[i]) begin
         runOp($sformatf("vec%0d", i), tbl[i]);
      end

      for (int i = 0; i < 40; i++) begin
         e = model(WIDTH'($urandom), WIDTH'($urandom));
         runOp($sformatf("rand%0d_%02h_%02h", i, e.a, e.b), e);
      end

      // Start pulsed mid-SHIFT is ignored; then start held in the DONE cycle
      // chains a second operation with no IDLE gap.
      applyStimulus(8'h05, 8'h03);
      @(negedge clk);
      @(negedge clk);
      a     = 8'h11;
      b     = 8'h22;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      waitDone(4, edges, bc);
      checkVal("ignore.latency", 32'(edges), 32'(WIDTH));
      checkOutput("ignore", model(8'h05, 8'h03));
      a     = 8'h10;
      b     = 8'h01;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checkVal("b2b.busy_immediate", 32'(busy), 32'd1);
      checkVal("b2b.done_cleared", 32'(done), 32'd0);
      waitDone(1, edges, bc);
      checkVal("b2b.latency", 32'(edges), 32'(WIDTH));
      checkVal("b2b.busy_cycles", 32'(bc), 32'(WIDTH));
      checkOutput("b2b", model(8'h10, 8'h01));

      // Reset in the middle of an operation discards it without a done pulse.
      runOp("pre_reset", model(8'h05, 8'h03));
      repeat (3) @(negedge clk);
      checkVal("idle_hold.c", 32'(c), 32'h02);
      checkVal("idle_hold.done", 32'(done), 32'd0);
      applyStimulus(8'h30, 8'h10);
      repeat (3) @(negedge clk);
      checkVal("mid_op_hold.c", 32'(c), 32'h02);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      checkReset("mid_op_reset");
      done_seen = 0;
      for (int k = 0; k < 2 * WIDTH; k++) begin
         if (done === 1'b1) done_seen++;
         @(negedge clk);
      end
      checkVal("mid_op_reset.no_done", 32'(done_seen), 32'd0);
      checkVal("mid_op_reset.c_still_zero", 32'(c), 32'd0);
      runOp("post_reset", model(8'h09, 8'h04));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
